// File: rtl/blink_pkg.sv
// Shared encodings for the multi-channel blink generator.
// Mode 3 is reserved and decodes as blink everywhere it is tested.
package blink_pkg;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_STEADY = 2'd1;
    localparam logic [1:0] MODE_BLINK  = 2'd2;

    localparam logic [1:0] S_OFF    = 2'd0;
    localparam logic [1:0] S_STEADY = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_OFF_PH = 2'd3;

    // Visible states drive blink_on high.
    function automatic logic state_visible(input logic [1:0] st);
        return (st == S_STEADY) || (st == S_ON);
    endfunction

endpackage

// File: rtl/blink_channel.sv
// One blink channel: mode FSM, phase counter and single-cycle toggle pulse.
// Advances only on the shared tick_edge strobe from the top level.
module blink_channel
    import blink_pkg::*;
#(
    parameter int CNT_BITS = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick_edge,
    input  logic [1:0]          mode,
    input  logic [CNT_BITS-1:0] on_len,
    input  logic [CNT_BITS-1:0] off_len,
    input  logic                restart,
    output logic                blink_on,
    output logic                toggle
);

    logic [1:0]          state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                blink_on_q, blink_on_d;
    logic                toggle_q, toggle_d;

    logic [CNT_BITS-1:0] on_last, off_last, cur_last;

    // A zero length behaves as one tick, so the last count index is 0.
    assign on_last  = (on_len  == '0) ? '0 : on_len  - CNT_BITS'(1);
    assign off_last = (off_len == '0) ? '0 : off_len - CNT_BITS'(1);
    assign cur_last = (state_q == S_ON) ? on_last : off_last;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        toggle_d = 1'b0;
        case (mode)
            MODE_OFF: begin
                state_d = S_OFF;
                cnt_d   = '0;
            end
            MODE_STEADY: begin
                state_d = S_STEADY;
                cnt_d   = '0;
            end
            default: begin
                if (state_q == S_OFF || state_q == S_STEADY || restart) begin
                    // Restart swallows a coincident tick edge on purpose.
                    state_d = S_ON;
                    cnt_d   = '0;
                end else if (tick_edge) begin
                    // >= lets a shortened length expire now instead of wrapping.
                    if (cnt_q >= cur_last) begin
                        state_d  = (state_q == S_ON) ? S_OFF_PH : S_ON;
                        cnt_d    = '0;
                        toggle_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
            end
        endcase
        blink_on_d = state_visible(state_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_OFF;
            cnt_q      <= '0;
            blink_on_q <= 1'b0;
            toggle_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            blink_on_q <= blink_on_d;
            toggle_q   <= toggle_d;
        end
    end

    assign blink_on = blink_on_q;
    assign toggle   = toggle_q;

endmodule

// File: rtl/blink_generator.sv
// Multi-channel blink generator driven by the vblank tick level.
// Define BLINK_TICK_SYNC_EN to add a 2-flop tick synchroniser (latency 3 cycles).
module blink_generator
    import blink_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int CNT_BITS = 6
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         tick,
    input  logic [2*CHANNELS-1:0]        mode,
    input  logic [CNT_BITS*CHANNELS-1:0] on_len,
    input  logic [CNT_BITS*CHANNELS-1:0] off_len,
    input  logic [CHANNELS-1:0]          reset_count,
    output logic [CHANNELS-1:0]          blink_on,
    output logic [CHANNELS-1:0]          toggle
);

    logic tick_s;
    logic tick_q;
    logic tick_edge;

`ifdef BLINK_TICK_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= tick;
            sync2_q <= sync1_q;
        end
    end

    assign tick_s = sync2_q;
`else
    assign tick_s = tick;
`endif

    // Cleared on reset so a tick already high after release counts once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tick_q <= 1'b0;
        else          tick_q <= tick_s;
    end

    assign tick_edge = tick_s & ~tick_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        blink_channel #(
            .CNT_BITS (CNT_BITS)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .tick_edge (tick_edge),
            .mode      (mode[g*2 +: 2]),
            .on_len    (on_len[g*CNT_BITS +: CNT_BITS]),
            .off_len   (off_len[g*CNT_BITS +: CNT_BITS]),
            .restart   (reset_count[g]),
            .blink_on  (blink_on[g]),
            .toggle    (toggle[g])
        );
    end

endmodule

// File: tb/tb_blink_generator.sv
// Directed bench for blink_generator: legacy timing, edge-only counting,
// restart/tick collision, length changes, channel independence, async reset.
module tb_blink_generator;

    localparam int CH = 2;
    localparam int CB = 6;
`ifdef BLINK_TICK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             tick;
    logic [2*CH-1:0]  mode;
    logic [CB*CH-1:0] on_len;
    logic [CB*CH-1:0] off_len;
    logic [CH-1:0]    reset_count;
    logic [CH-1:0]    blink_on;
    logic [CH-1:0]    toggle;

    int n_chk  = 0;
    int n_pass = 0;
    int tcnt0  = 0;
    int tcnt1  = 0;

    blink_generator #(.CHANNELS(CH), .CNT_BITS(CB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (tick),
        .mode        (mode),
        .on_len      (on_len),
        .off_len     (off_len),
        .reset_count (reset_count),
        .blink_on    (blink_on),
        .toggle      (toggle)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (toggle[0] === 1'b1) tcnt0++;
        if (toggle[1] === 1'b1) tcnt1++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Rising tick; returns at the sample point where the edge has taken effect.
    task automatic tick_pulse;
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (LAT - 1) step();
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            tick_pulse();
            step();
        end
    endtask

    // Channel 0 back to S_ON with counter 0 via a pass through OFF.
    task automatic restart0(input logic [CB-1:0] on, input logic [CB-1:0] off);
        mode[1:0] = 2'd0;
        step();
        on_len[CB-1:0]  = on;
        off_len[CB-1:0] = off;
        mode[1:0] = 2'd2;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int lat;
        int errs;
        int t0;
        int t1;
        logic exp_on;
        logic exp_tg;

        reset_n     = 1'b0;
        tick        = 1'b0;
        mode        = '0;
        on_len      = '0;
        off_len     = '0;
        reset_count = '0;
        step();
        step();
        chk("reset_blink_on", blink_on, 0);
        chk("reset_toggle", toggle, 0);
        reset_n = 1'b1;
        step();

        // Latency from tick rise to blink_on change.
        restart0(6'd1, 6'd1);
        chk("blink_entry_on", blink_on[0], 1);
        lat  = 0;
        tick = 1'b1;
        while (blink_on[0] !== 1'b0 && lat < 10) begin
            step();
            lat++;
            tick = 1'b0;
        end
        chk("tick_latency", lat, LAT);
        chk("latency_toggle", toggle[0], 1);
        step();
        step();

        // Legacy 32/32 blinker, tick every 10 cycles.
        restart0(6'd32, 6'd32);
        t0   = tcnt0;
        errs = 0;
        for (int e = 1; e <= 64; e++) begin
            tick_pulse();
            exp_on = !(e >= 32 && e < 64);
            exp_tg = (e == 32) || (e == 64);
            if (blink_on[0] !== exp_on) errs++;
            if (toggle[0] !== exp_tg) errs++;
            if (e == 32) chk("legacy_off_at_32", blink_on[0], 0);
            if (e == 64) chk("legacy_on_at_64", blink_on[0], 1);
            repeat (10 - LAT) step();
        end
        chk("legacy_seq_errs", errs, 0);
        chk("legacy_toggle_count", tcnt0 - t0, 2);

        // Level held high counts once.
        restart0(6'd3, 6'd3);
        tick = 1'b1;
        repeat (100) step();
        tick = 1'b0;
        repeat (LAT + 1) step();
        chk("hold_counts_once", blink_on[0], 1);
        pulses(1);
        chk("hold_plus1_on", blink_on[0], 1);
        tick_pulse();
        chk("hold_plus2_off", blink_on[0], 0);
        step();

        // Five short pulses advance by five.
        restart0(6'd6, 6'd6);
        pulses(5);
        chk("five_pulses_on", blink_on[0], 1);
        tick_pulse();
        chk("sixth_pulse_off", blink_on[0], 0);
        chk("sixth_pulse_toggle", toggle[0], 1);
        step();

        // reset_count colliding with a tick edge in S_OFF_PH, counter 7.
        restart0(6'd2, 6'd10);
        pulses(2);
        chk("rc_in_off_phase", blink_on[0], 0);
        pulses(7);
        chk("rc_still_off_cnt7", blink_on[0], 0);
        tick = 1'b1;
        repeat (LAT - 1) begin
            step();
            tick = 1'b0;
        end
        reset_count[0] = 1'b1;
        step();
        reset_count[0] = 1'b0;
        tick = 1'b0;
        chk("rc_back_on", blink_on[0], 1);
        chk("rc_no_toggle", toggle[0], 0);
        step();
        tick_pulse();
        chk("rc_next_edge_cnt1", blink_on[0], 1);
        step();
        tick_pulse();
        chk("rc_second_edge_off", blink_on[0], 0);
        step();

        // Shortening on_len mid-phase expires at the next edge.
        restart0(6'd20, 6'd10);
        pulses(15);
        chk("shorten_pre_on", blink_on[0], 1);
        on_len[CB-1:0] = 6'd4;
        tick_pulse();
        chk("shorten_expire_off", blink_on[0], 0);
        chk("shorten_toggle", toggle[0], 1);
        step();
        off_len[CB-1:0] = 6'd0;
        tick_pulse();
        chk("off_len0_one_tick", blink_on[0], 1);
        step();
        on_len[CB-1:0] = 6'd0;
        tick_pulse();
        chk("on_len0_one_tick", blink_on[0], 0);
        step();

        // Independent channels; mode change never pulses toggle.
        mode[3:2] = 2'd1;
        restart0(6'd2, 6'd3);
        chk("ch1_steady", blink_on[1], 1);
        t0 = tcnt0;
        t1 = tcnt1;
        pulses(1);
        chk("ch0_mid_on", blink_on[0], 1);
        mode[1:0] = 2'd0;
        step();
        chk("ch0_mode_off", blink_on[0], 0);
        chk("ch0_mode_no_toggle", tcnt0 - t0, 0);
        reset_count[1] = 1'b1;
        step();
        reset_count[1] = 1'b0;
        pulses(2);
        chk("ch_outputs_10", blink_on, 2'b10);
        chk("ch1_no_toggle", tcnt1 - t1, 0);

        // Asynchronous reset between clock edges.
        restart0(6'd5, 6'd5);
        chk("pre_reset_both_on", blink_on, 2'b11);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #2;
        chk("async_reset_blink_on", blink_on, 0);
        chk("async_reset_toggle", toggle, 0);
        #2;
        reset_n = 1'b1;
        step();
        chk("post_reset_recover", blink_on, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
